// File: rtl/ltm_ui_pkg.sv
`default_nettype none
//============================================================================
// ltm_ui_pkg : shared types, pixel boundaries and region decode helpers
// Rev 1.0
//============================================================================
package ltm_ui_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   typedef logic [2:0] region_t;
   typedef logic [2:0] rgb_code_t;

   localparam logic [9:0] PIX_COL1 = 10'd200;
   localparam logic [9:0] PIX_COL2 = 10'd400;
   localparam logic [9:0] PIX_COL3 = 10'd600;
   localparam logic [9:0] PIX_ROW1 = 10'd240;

   // Region index is row*4+col, i.e. {row, col[1:0]}.
   function automatic region_t touch_region(
      input logic [11:0] x,
      input logic [11:0] y,
      input logic [11:0] t1,
      input logic [11:0] t2,
      input logic [11:0] t3,
      input logic [11:0] ty
   );
      logic [1:0] col;
      logic       row;
      if (x < t1)      col = 2'd0;
      else if (x < t2) col = 2'd1;
      else if (x < t3) col = 2'd2;
      else             col = 2'd3;
      row = (y >= ty);
      return {row, col};
   endfunction

   function automatic region_t pixel_region(
      input logic [9:0] px,
      input logic [9:0] py
   );
      logic [1:0] col;
      logic       row;
      if (px < PIX_COL1)      col = 2'd0;
      else if (px < PIX_COL2) col = 2'd1;
      else if (px < PIX_COL3) col = 2'd2;
      else                    col = 2'd3;
      row = (py >= PIX_ROW1);
      return {row, col};
   endfunction

endpackage
`default_nettype wire

// File: rtl/tp_region_colour_gen.sv
`default_nettype none
//============================================================================
// tp_region_colour_gen : per-region colour-code table and registered RGB
// Rev 1.0
//============================================================================
module tp_region_colour_gen
   import ltm_ui_pkg::*;
(
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       i_accept,
   input  region_t    i_acc_region,
   input  logic [9:0] i_pixel_x,
   input  logic [9:0] i_pixel_y,
   output logic [7:0] o_red,
   output logic [7:0] o_green,
   output logic [7:0] o_blue
);

   rgb_code_t r_code [8];
   region_t   w_pix_region;
   rgb_code_t w_code;

   // Each region powers up showing its own index as colour code.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < 8; i++) begin
            r_code[i] <= 3'(i);
         end
      end else if (i_accept) begin
         r_code[i_acc_region] <= r_code[i_acc_region] + 3'd1;
      end
   end

   assign w_pix_region = pixel_region(i_pixel_x, i_pixel_y);
   assign w_code       = r_code[w_pix_region];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         o_red   <= 8'h00;
         o_green <= 8'h00;
         o_blue  <= 8'h00;
      end else begin
         o_red   <= {8{w_code[2]}};
         o_green <= {8{w_code[1]}};
         o_blue  <= {8{w_code[0]}};
      end
   end

endmodule
`default_nettype wire

// File: rtl/tp_region_controller.sv
`default_nettype none
//============================================================================
// tp_region_controller : touch debounce, region select and colour-bar control
// Optional: AUTO_REPEAT_EN adds auto-repeat while the pen is held.  Rev 1.0
//============================================================================
module tp_region_controller
   import ltm_ui_pkg::*;
#(
   parameter int          DEBOUNCE_N = 4,
   parameter logic [11:0] X_T1       = 12'h400,
   parameter logic [11:0] X_T2       = 12'h800,
   parameter logic [11:0] X_T3       = 12'hC00,
   parameter logic [11:0] Y_T        = 12'h800
`ifdef AUTO_REPEAT_EN
   ,
   parameter int          REPEAT_N   = 16
`endif
)(
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Touch_En,
   input  logic        Coord_En,
   input  logic [11:0] X_Coord,
   input  logic [11:0] Y_Coord,
   input  logic [9:0]  Pixel_X,
   input  logic [9:0]  Pixel_Y,
   output logic [7:0]  Red,
   output logic [7:0]  Green,
   output logic [7:0]  Blue,
   output logic        Region_Valid,
   output logic [2:0]  Region_Sel,
   output logic        Busy
);

   localparam logic [3:0] c_DEB = 4'(DEBOUNCE_N);

   state_t     r_state;
   state_t     w_state_nx;
   region_t    r_cand;
   region_t    w_cand_nx;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nx;
   region_t    r_region_sel;
   logic       r_region_valid;
   region_t    w_touch_region;
   region_t    w_acc_region;
   logic       w_accept;

`ifdef AUTO_REPEAT_EN
   localparam int                  c_RCNT_W   = $clog2(REPEAT_N + 1);
   localparam logic [c_RCNT_W-1:0] c_REP_LAST = c_RCNT_W'(REPEAT_N - 1);

   logic [c_RCNT_W-1:0] r_rcnt;
   logic [c_RCNT_W-1:0] w_rcnt_nx;
`endif

   assign w_touch_region = touch_region(X_Coord, Y_Coord, X_T1, X_T2, X_T3, Y_T);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state        <= IDLE;
         r_cand         <= '0;
         r_cnt          <= '0;
         r_region_sel   <= '0;
         r_region_valid <= 1'b0;
`ifdef AUTO_REPEAT_EN
         r_rcnt         <= '0;
`endif
      end else begin
         r_state        <= w_state_nx;
         r_cand         <= w_cand_nx;
         r_cnt          <= w_cnt_nx;
         r_region_valid <= w_accept;
         if (w_accept) begin
            r_region_sel <= w_acc_region;
         end
`ifdef AUTO_REPEAT_EN
         r_rcnt         <= w_rcnt_nx;
`endif
      end
   end

   // Release (Touch_En low) is checked before Coord_En in every busy state.
   always_comb begin
      w_state_nx   = r_state;
      w_cand_nx    = r_cand;
      w_cnt_nx     = r_cnt;
      w_accept     = 1'b0;
      w_acc_region = r_cand;
`ifdef AUTO_REPEAT_EN
      w_rcnt_nx    = r_rcnt;
`endif
      case (r_state)
         IDLE: begin
            if (Coord_En && Touch_En) begin
               w_cand_nx  = w_touch_region;
               w_cnt_nx   = 4'd1;
               w_state_nx = SAMPLE;
            end
         end
         SAMPLE: begin
            if (!Touch_En) begin
               w_cnt_nx   = 4'd0;
               w_state_nx = IDLE;
            end else if (Coord_En) begin
               if (w_touch_region == r_cand) begin
                  if ((r_cnt + 4'd1) == c_DEB) begin
                     w_accept   = 1'b1;
                     w_cnt_nx   = 4'd0;
                     w_state_nx = HOLD;
`ifdef AUTO_REPEAT_EN
                     w_rcnt_nx  = '0;
`endif
                  end else begin
                     w_cnt_nx = r_cnt + 4'd1;
                  end
               end else begin
                  w_cand_nx = w_touch_region;
                  w_cnt_nx  = 4'd1;
               end
            end
         end
         HOLD: begin
            if (!Touch_En) begin
               w_state_nx = IDLE;
`ifdef AUTO_REPEAT_EN
            end else if (Coord_En) begin
               if (w_touch_region == r_region_sel) begin
                  if (r_rcnt == c_REP_LAST) begin
                     w_accept     = 1'b1;
                     w_acc_region = r_region_sel;
                     w_rcnt_nx    = '0;
                  end else begin
                     w_rcnt_nx = r_rcnt + 1'b1;
                  end
               end else begin
                  w_rcnt_nx = '0;
               end
`endif
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   tp_region_colour_gen u_colour_gen (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .i_accept     (w_accept),
      .i_acc_region (w_acc_region),
      .i_pixel_x    (Pixel_X),
      .i_pixel_y    (Pixel_Y),
      .o_red        (Red),
      .o_green      (Green),
      .o_blue       (Blue)
   );

   assign Region_Valid = r_region_valid;
   assign Region_Sel   = r_region_sel;
   assign Busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tp_region_controller.sv
`default_nettype none
//============================================================================
// tb_tp_region_controller : directed stimulus with queued expected responses
// Rev 1.0
//============================================================================
module tb_tp_region_controller;

   logic        Clock;
   logic        Resetn;
   logic        Touch_En;
   logic        Coord_En;
   logic [11:0] X_Coord;
   logic [11:0] Y_Coord;
   logic [9:0]  Pixel_X;
   logic [9:0]  Pixel_Y;
   logic [7:0]  Red;
   logic [7:0]  Green;
   logic [7:0]  Blue;
   logic        Region_Valid;
   logic [2:0]  Region_Sel;
   logic        Busy;

   int          n_vec = 0;
   int          n_err = 0;

   logic [2:0]  rv_q  [$];
   logic [23:0] pix_q [$];
   logic        pix_req  = 1'b0;
   logic        pix_pend = 1'b0;

   tp_region_controller dut (
      .Clock        (Clock),
      .Resetn       (Resetn),
      .Touch_En     (Touch_En),
      .Coord_En     (Coord_En),
      .X_Coord      (X_Coord),
      .Y_Coord      (Y_Coord),
      .Pixel_X      (Pixel_X),
      .Pixel_Y      (Pixel_Y),
      .Red          (Red),
      .Green        (Green),
      .Blue         (Blue),
      .Region_Valid (Region_Valid),
      .Region_Sel   (Region_Sel),
      .Busy         (Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   always @(posedge Clock) pix_pend <= pix_req;

   // Monitor: every Region_Valid cycle and every requested pixel response pops one entry.
   always @(negedge Clock) begin
      if (Resetn === 1'b1 && Region_Valid === 1'b1) begin
         n_vec++;
         if (rv_q.size() == 0) begin
            n_err++;
            $display("FAIL region_valid: unexpected pulse with sel=%0d, expected no pulse", Region_Sel);
         end else begin
            logic [2:0] e;
            e = rv_q.pop_front();
            if (Region_Sel !== e) begin
               n_err++;
               $display("FAIL region_sel_on_valid: got %0d, expected %0d", Region_Sel, e);
            end
         end
      end
      if (pix_pend) begin
         logic [23:0] e;
         n_vec++;
         e = (pix_q.size() != 0) ? pix_q.pop_front() : 24'hxxxxxx;
         if ({Red, Green, Blue} !== e) begin
            n_err++;
            $display("FAIL pixel_rgb: got %h, expected %h", {Red, Green, Blue}, e);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sample(input logic [11:0] x, input logic [11:0] y);
      @(posedge Clock); #1;
      X_Coord  = x;
      Y_Coord  = y;
      Coord_En = 1'b1;
      @(posedge Clock); #1;
      Coord_En = 1'b0;
   endtask

   task automatic release_pen();
      @(posedge Clock); #1;
      Touch_En = 1'b0;
      @(posedge Clock); #1;
   endtask

   task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic [23:0] exp);
      @(posedge Clock); #1;
      Pixel_X = px;
      Pixel_Y = py;
      pix_q.push_back(exp);
      pix_req = 1'b1;
      @(posedge Clock); #1;
      pix_req = 1'b0;
      @(negedge Clock);
   endtask

   task automatic busy_is(input string name, input logic exp);
      @(negedge Clock);
      chk(name, {31'd0, Busy}, {31'd0, exp});
   endtask

   initial begin
      Resetn   = 1'b0;
      Touch_En = 1'b0;
      Coord_En = 1'b0;
      X_Coord  = '0;
      Y_Coord  = '0;
      Pixel_X  = '0;
      Pixel_Y  = '0;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      chk("reset_rgb",          {8'd0, Red, Green, Blue}, 32'h0);
      chk("reset_region_valid", {31'd0, Region_Valid}, 32'd0);
      chk("reset_region_sel",   {29'd0, Region_Sel}, 32'd0);
      chk("reset_busy",         {31'd0, Busy}, 32'd0);
      @(posedge Clock); #1;
      Resetn = 1'b1;

      // Reset colour codes: region 2 holds code 2.
      pixel(10'd500, 10'd100, 24'h00FF00);

      // Coord_En without pen-down is ignored.
      sample(12'h900, 12'h300);
      busy_is("idle_ignores_no_touch", 1'b0);

      // Debounced press in region 2.
      Touch_En = 1'b1;
      sample(12'h900, 12'h300);
      busy_is("busy_in_sample", 1'b1);
      sample(12'h900, 12'h300);
      sample(12'h900, 12'h300);
      rv_q.push_back(3'd2);
      sample(12'h900, 12'h300);
      chk("region_sel_r2", {29'd0, Region_Sel}, 32'd2);
      release_pen();
      busy_is("idle_after_r2", 1'b0);
      pixel(10'd500, 10'd100, 24'h00FFFF);

      // Alternating regions 2/3 on the exact thresholds never settle.
      Touch_En = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample((i % 2 == 0) ? 12'h800 : 12'hC00, 12'h300);
      end
      busy_is("busy_alternating", 1'b1);
      release_pen();
      busy_is("idle_after_alternating", 1'b0);

      // Region 7 press wraps its code from 7 to 0; drag in HOLD is ignored.
      Touch_En = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rv_q.push_back(3'd7);
         sample(12'hF00, 12'hF00);
      end
      sample(12'h500, 12'hF00);
      busy_is("busy_in_hold_drag", 1'b1);
      chk("region_sel_r7", {29'd0, Region_Sel}, 32'd7);
      release_pen();
      pixel(10'd700, 10'd400, 24'h000000);
      pixel(10'd600, 10'd240, 24'h000000);
      pixel(10'd599, 10'd239, 24'h00FFFF);

      // Long hold in region 0.
      Touch_En = 1'b1;
      for (int i = 1; i <= 40; i++) begin
`ifdef AUTO_REPEAT_EN
         if (i == 4 || i == 20 || i == 36) rv_q.push_back(3'd0);
`else
         if (i == 4) rv_q.push_back(3'd0);
`endif
         sample(12'h100, 12'h100);
      end
      release_pen();
      chk("region_sel_r0", {29'd0, Region_Sel}, 32'd0);
`ifdef AUTO_REPEAT_EN
      pixel(10'd100, 10'd100, 24'h00FFFF);
`else
      pixel(10'd100, 10'd100, 24'h0000FF);
`endif

      // Asynchronous reset in the middle of debouncing region 1.
      Touch_En = 1'b1;
      for (int i = 0; i < 3; i++) sample(12'h500, 12'h100);
      #2;
      Resetn = 1'b0;
      #1;
      chk("busy_async_reset", {31'd0, Busy}, 32'd0);
      repeat (2) @(posedge Clock);
      #1;
      Resetn = 1'b1;
      for (int i = 0; i < 3; i++) sample(12'h500, 12'h100);
      busy_is("busy_after_reset_3", 1'b1);
      rv_q.push_back(3'd1);
      sample(12'h500, 12'h100);
      chk("region_sel_r1", {29'd0, Region_Sel}, 32'd1);
      release_pen();
      pixel(10'd300, 10'd100, 24'h00FF00);
      pixel(10'd500, 10'd100, 24'h00FF00);

      repeat (4) @(posedge Clock);
      @(negedge Clock);
      chk("valid_queue_drained", rv_q.size(), 32'd0);
      chk("pixel_queue_drained", pix_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
